// File: rtl/m72_pkg.sv
// Shared types for the memory-map decoder: region table entry, FSM states,
// the match helper and the per-board decode tables.
package m72_pkg;

  localparam int unsigned CFG_ADDR_W = 20;
  localparam int unsigned CFG_SDR_W  = 24;

  typedef struct packed {
    logic                  valid;
    logic [CFG_ADDR_W-1:0] match;
    logic [CFG_ADDR_W-1:0] care;
    logic [CFG_SDR_W-1:0]  sdr_base;
    logic                  writable;
  } region_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    REQ,
    DONE
  } dec_state_t;

  function automatic logic region_hit(input region_cfg_t c, input logic [CFG_ADDR_W-1:0] a);
    return c.valid && (((a ^ c.match) & c.care) == '0);
  endfunction

  localparam int unsigned BOARD_ENTRIES = 3;

  // Board tables, written into the decoder one entry per cfg_we strobe.
  localparam region_cfg_t RTYPE_MAP [BOARD_ENTRIES] = '{
    '{1'b1, 20'h00000, 20'hC0000, 24'h000000, 1'b0},
    '{1'b1, 20'h40000, 20'hF0000, 24'h080000, 1'b1},
    '{1'b1, 20'hA0000, 20'hF0000, 24'h0A0000, 1'b1}
  };
  localparam region_cfg_t GALLOP_MAP [BOARD_ENTRIES] = '{
    '{1'b1, 20'h00000, 20'h80000, 24'h000000, 1'b0},
    '{1'b1, 20'h80000, 20'hE0000, 24'h100000, 1'b1},
    '{1'b1, 20'hB0000, 20'hF0000, 24'h110000, 1'b1}
  };
  localparam region_cfg_t DBREED_MAP [BOARD_ENTRIES] = '{
    '{1'b1, 20'h00000, 20'hC0000, 24'h000000, 1'b0},
    '{1'b1, 20'h80000, 20'hF8000, 24'h040000, 1'b1},
    '{1'b1, 20'hE0000, 20'hE0000, 24'h200000, 1'b1}
  };

endpackage

// File: rtl/mem_map_decoder_region_match.sv
// Combinational region matcher: the lowest-index hitting entry wins.
module region_match
  import m72_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 8
) (
  input  region_cfg_t                      regions [NUM_REGIONS],
  input  logic [CFG_ADDR_W-1:0]            addr,
  output logic                             hit,
  output logic [$clog2(NUM_REGIONS)-1:0]   idx,
  output logic                             writable,
  output logic [CFG_ADDR_W-1:0]            care,
  output logic [CFG_SDR_W-1:0]             sdr_base
);

  localparam int unsigned IDX_W = $clog2(NUM_REGIONS);

  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    writable = 1'b0;
    care     = '0;
    sdr_base = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!hit && region_hit(regions[i], addr)) begin
        hit      = 1'b1;
        idx      = IDX_W'(i);
        writable = regions[i].writable;
        care     = regions[i].care;
        sdr_base = regions[i].sdr_base;
      end
    end
  end

endmodule

// File: rtl/mem_map_decoder.sv
// CPU-to-SDRAM memory-map decoder: programmable window table, single
// outstanding access FSM with ack timeout and sticky error flag.
module mem_map_decoder
  import m72_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 8,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned SDR_W       = 24,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_REGIONS)-1:0] cfg_idx,
  input  logic                           cfg_valid,
  input  logic [ADDR_W-1:0]              cfg_match,
  input  logic [ADDR_W-1:0]              cfg_care,
  input  logic [SDR_W-1:0]               cfg_sdr_base,
  input  logic                           cfg_writable,
  input  logic                           cpu_req,
  input  logic                           cpu_m_io,
  input  logic [ADDR_W-1:0]              cpu_addr,
  input  logic                           cpu_we,
  output logic                           cpu_ready,
  output logic                           cpu_hit,
  output logic [$clog2(NUM_REGIONS)-1:0] cpu_region,
  output logic                           sdr_req,
  output logic [SDR_W-1:0]               sdr_addr,
  output logic                           sdr_we,
  input  logic                           sdr_ack,
  output logic                           err,
  input  logic                           err_clr
);

  localparam int unsigned IDX_W = $clog2(NUM_REGIONS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  region_cfg_t             regions [NUM_REGIONS];
  dec_state_t              state, state_n;
  logic [ADDR_W-1:0]       addr_q;
  logic                    we_q;
  logic [CNT_W-1:0]        cnt;
  logic                    timeout;

  logic                    m_hit;
  logic [IDX_W-1:0]        m_idx;
  logic                    m_writable;
  logic [CFG_ADDR_W-1:0]   m_care;
  logic [CFG_SDR_W-1:0]    m_sdr_base;
  logic [ADDR_W-1:0]       word_off;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) regions[i] <= '0;
    end else if (cfg_we) begin
      regions[cfg_idx] <= '{valid:    cfg_valid,
                            match:    CFG_ADDR_W'(cfg_match),
                            care:     CFG_ADDR_W'(cfg_care),
                            sdr_base: CFG_SDR_W'(cfg_sdr_base),
                            writable: cfg_writable};
    end
  end

  region_match #(.NUM_REGIONS(NUM_REGIONS)) u_match (
    .regions  (regions),
    .addr     (CFG_ADDR_W'(addr_q)),
    .hit      (m_hit),
    .idx      (m_idx),
    .writable (m_writable),
    .care     (m_care),
    .sdr_base (m_sdr_base)
  );

  // Byte address bits outside the care mask become the SDRAM word offset.
  assign word_off = (addr_q & ~ADDR_W'(m_care)) >> 1;

  always_comb begin
    state_n = state;
    timeout = 1'b0;
    case (state)
      IDLE:   if (cpu_req && cpu_m_io) state_n = DECODE;
      DECODE: state_n = (m_hit && (!we_q || m_writable)) ? REQ : DONE;
      REQ: begin
        if (sdr_ack) begin
          state_n = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_n = DONE;
        end
      end
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      cnt        <= '0;
      err        <= 1'b0;
      cpu_hit    <= 1'b0;
      cpu_region <= '0;
      sdr_addr   <= '0;
      sdr_we     <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && cpu_req && cpu_m_io) begin
        addr_q <= cpu_addr;
        we_q   <= cpu_we;
      end
      if (state == DECODE) begin
        cpu_hit    <= m_hit;
        cpu_region <= m_idx;
        sdr_addr   <= SDR_W'(m_sdr_base) | SDR_W'(word_off);
        sdr_we     <= we_q;
        cnt        <= '0;
      end
      if (state == REQ && !sdr_ack && !timeout) cnt <= cnt + 1'b1;
      if (timeout)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  // Both derive from state so an async reset drops them immediately.
  assign sdr_req   = (state == REQ);
  assign cpu_ready = (state == DONE);

endmodule

// File: tb/tb_mem_map_decoder.sv
// Directed self-checking bench for mem_map_decoder (TIMEOUT overridden to 4).
module tb_mem_map_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_we, cfg_valid, cfg_writable;
  logic [2:0]  cfg_idx;
  logic [19:0] cfg_match, cfg_care;
  logic [23:0] cfg_sdr_base;
  logic        cpu_req, cpu_m_io, cpu_we;
  logic [19:0] cpu_addr;
  logic        cpu_ready, cpu_hit;
  logic [2:0]  cpu_region;
  logic        sdr_req, sdr_we, sdr_ack;
  logic [23:0] sdr_addr;
  logic        err, err_clr;

  int checks = 0;
  int errors = 0;

  mem_map_decoder #(
    .NUM_REGIONS (8),
    .ADDR_W      (20),
    .SDR_W       (24),
    .TIMEOUT     (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_valid    (cfg_valid),
    .cfg_match    (cfg_match),
    .cfg_care     (cfg_care),
    .cfg_sdr_base (cfg_sdr_base),
    .cfg_writable (cfg_writable),
    .cpu_req      (cpu_req),
    .cpu_m_io     (cpu_m_io),
    .cpu_addr     (cpu_addr),
    .cpu_we       (cpu_we),
    .cpu_ready    (cpu_ready),
    .cpu_hit      (cpu_hit),
    .cpu_region   (cpu_region),
    .sdr_req      (sdr_req),
    .sdr_addr     (sdr_addr),
    .sdr_we       (sdr_we),
    .sdr_ack      (sdr_ack),
    .err          (err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic write_entry(input logic [2:0] idx, input logic v, input logic [19:0] m,
                             input logic [19:0] c, input logic [23:0] b, input logic w);
    cfg_idx = idx; cfg_valid = v; cfg_match = m; cfg_care = c;
    cfg_sdr_base = b; cfg_writable = w; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // Presents a memory request for one edge; returns in cycle 1 (DECODE).
  task automatic start(input logic [19:0] a, input logic w);
    cpu_req = 1'b1; cpu_m_io = 1'b1; cpu_addr = a; cpu_we = w;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0;
    cfg_match = '0; cfg_care = '0; cfg_sdr_base = '0; cfg_writable = 1'b0;
    cpu_req = 1'b0; cpu_m_io = 1'b0; cpu_addr = '0; cpu_we = 1'b0;
    sdr_ack = 1'b0; err_clr = 1'b0;
    tick(); tick();
    check("rst_ready",  32'(cpu_ready),  32'd0);
    check("rst_sdrreq", 32'(sdr_req),    32'd0);
    check("rst_err",    32'(err),        32'd0);
    check("rst_hit",    32'(cpu_hit),    32'd0);
    check("rst_region", 32'(cpu_region), 32'd0);
    check("rst_addr",   32'(sdr_addr),   32'd0);
    reset_n = 1'b1;
    tick();

    write_entry(3'd0, 1'b1, 20'h40000, 20'hE0000, 24'h100000, 1'b1);
    write_entry(3'd1, 1'b1, 20'h00000, 20'hC0000, 24'h200000, 1'b0);

    // Read hitting entry 0
    start(20'h41234, 1'b0);
    check("rd_c1_sdrreq", 32'(sdr_req), 32'd0);
    tick();
    check("rd_c2_sdrreq", 32'(sdr_req),    32'd1);
    check("rd_c2_addr",   32'(sdr_addr),   32'h10091A);
    check("rd_c2_we",     32'(sdr_we),     32'd0);
    check("rd_c2_hit",    32'(cpu_hit),    32'd1);
    check("rd_c2_region", 32'(cpu_region), 32'd0);
    tick();
    check("rd_c3_sdrreq", 32'(sdr_req),  32'd1);
    check("rd_c3_addr",   32'(sdr_addr), 32'h10091A);
    check("rd_c3_ready",  32'(cpu_ready), 32'd0);
    sdr_ack = 1'b1;
    tick();
    sdr_ack = 1'b0;
    check("rd_ack_ready",  32'(cpu_ready), 32'd1);
    check("rd_ack_sdrreq", 32'(sdr_req),   32'd0);
    tick();
    check("rd_ready_once", 32'(cpu_ready), 32'd0);
    check("rd_err",        32'(err),       32'd0);

    // Write to read-only entry 1: dropped, but decoded as a hit
    start(20'h01000, 1'b1);
    check("ro_c1_sdrreq", 32'(sdr_req), 32'd0);
    tick();
    check("ro_c2_ready",  32'(cpu_ready),  32'd1);
    check("ro_c2_sdrreq", 32'(sdr_req),    32'd0);
    check("ro_c2_hit",    32'(cpu_hit),    32'd1);
    check("ro_c2_region", 32'(cpu_region), 32'd1);
    tick();

    // Miss
    start(20'hD0000, 1'b0);
    tick();
    check("miss_ready",  32'(cpu_ready), 32'd1);
    check("miss_hit",    32'(cpu_hit),   32'd0);
    check("miss_sdrreq", 32'(sdr_req),   32'd0);
    tick();

    // I/O cycle and stray ack in IDLE are ignored
    cpu_req = 1'b1; cpu_m_io = 1'b0; cpu_addr = 20'h41234; sdr_ack = 1'b1;
    tick(); tick();
    cpu_req = 1'b0; sdr_ack = 1'b0;
    check("io_ready",  32'(cpu_ready), 32'd0);
    check("io_sdrreq", 32'(sdr_req),   32'd0);
    tick();
    check("io_ready2", 32'(cpu_ready), 32'd0);

    // Timeout after 4 REQ cycles
    start(20'h41234, 1'b0);
    tick(); tick(); tick(); tick();
    check("to_c5_sdrreq", 32'(sdr_req),   32'd1);
    check("to_c5_err",    32'(err),       32'd0);
    check("to_c5_ready",  32'(cpu_ready), 32'd0);
    tick();
    check("to_c6_ready", 32'(cpu_ready), 32'd1);
    check("to_c6_err",   32'(err),       32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr", 32'(err), 32'd0);
    tick();

    // Timeout with err_clr held: set wins, then clear takes effect
    start(20'h41234, 1'b0);
    err_clr = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check("setwin_err",   32'(err),       32'd1);
    check("setwin_ready", 32'(cpu_ready), 32'd1);
    tick();
    err_clr = 1'b0;
    check("setwin_clr", 32'(err), 32'd0);

    // Ack on the 4th REQ cycle beats the timeout
    start(20'h41234, 1'b0);
    tick(); tick(); tick(); tick();
    sdr_ack = 1'b1;
    tick();
    sdr_ack = 1'b0;
    check("ackto_ready", 32'(cpu_ready), 32'd1);
    check("ackto_err",   32'(err),       32'd0);
    tick();

    // Priority: entries 2 and 5 both hit 0x81000
    write_entry(3'd2, 1'b1, 20'h80000, 20'hF0000, 24'h300000, 1'b1);
    write_entry(3'd5, 1'b1, 20'h80000, 20'hC0000, 24'h500000, 1'b1);
    start(20'h81000, 1'b1);
    tick();
    check("pri_region", 32'(cpu_region), 32'd2);
    check("pri_addr",   32'(sdr_addr),   32'h300800);
    check("pri_we",     32'(sdr_we),     32'd1);
    write_entry(3'd2, 1'b0, 20'h80000, 20'hF0000, 24'h300000, 1'b1);
    check("pri_mid_region", 32'(cpu_region), 32'd2);
    check("pri_mid_addr",   32'(sdr_addr),   32'h300800);
    check("pri_mid_sdrreq", 32'(sdr_req),    32'd1);
    sdr_ack = 1'b1;
    tick();
    sdr_ack = 1'b0;
    check("pri_ready", 32'(cpu_ready), 32'd1);
    tick();
    start(20'h81000, 1'b0);
    tick();
    check("pri2_region", 32'(cpu_region), 32'd5);
    check("pri2_addr",   32'(sdr_addr),   32'h500800);
    sdr_ack = 1'b1;
    tick();
    sdr_ack = 1'b0;
    tick();

    // Reset during REQ
    start(20'h81000, 1'b0);
    tick();
    check("mr_sdrreq_pre", 32'(sdr_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mr_sdrreq_drop", 32'(sdr_req), 32'd0);
    tick();
    check("mr_ready_rst", 32'(cpu_ready), 32'd0);
    reset_n = 1'b1;
    tick();
    check("mr_ready_after", 32'(cpu_ready), 32'd0);
    tick();
    check("mr_ready_after2", 32'(cpu_ready), 32'd0);
    start(20'h81000, 1'b0);
    tick();
    check("mr_inv_hit",    32'(cpu_hit),   32'd0);
    check("mr_inv_ready",  32'(cpu_ready), 32'd1);
    check("mr_inv_sdrreq", 32'(sdr_req),   32'd0);
    tick();
    start(20'h41234, 1'b0);
    tick();
    check("mr_inv0_hit", 32'(cpu_hit), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
